source_switch_mute: RTL and testbench
=====================================

SOURCE_SWITCH_MUTE -- requirements
Module: source_switch_mute

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, sample word width per channel.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 1024, muted frames after a switch, legal range 1..65535.
REQ-003 SHALL have port clk  input  1  system clock, 49.152 MHz mclk domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port selectionresult  input  1  debounced source select, 0=source 0, 1=source 1.
REQ-006 SHALL have port selectionchanged  input  1  level flag, high while the upstream selection is changing.
REQ-007 SHALL have ports s0_valid/s1_valid  input  1  one-clk frame strobe per source.
REQ-008 SHALL have ports s0_left, s0_right, s1_left, s1_right  input  DATA_WIDTH  two's-complement samples, valid with the strobe.
REQ-009 SHALL have port out_valid  output  1  one-clk frame strobe.
REQ-010 SHALL have ports out_left, out_right  output  DATA_WIDTH  output samples.
REQ-011 SHALL have port mute  output  1  high while output is forced to zero, DAC mute pin.
REQ-012 SHALL have port active_source  output  1  currently routed source.

Function
REQ-013 SHALL implement one FSM with states PLAY, MUTE, SWITCH, SETTLE, all transitions on posedge clk.
REQ-014 PLAY: selectionchanged=1 -> MUTE; else stay.
REQ-015 MUTE: stay while selectionchanged=1; selectionchanged=0 -> SWITCH.
REQ-016 SWITCH: lasts exactly one clk; active_source <= selectionresult; settle counter <= 0; -> SETTLE.
REQ-017 SETTLE: settle counter (16 bit) increments on each selected-source valid strobe; on the strobe where counter == SETTLE_FRAMES-1 -> PLAY.
REQ-018 SETTLE: selectionchanged=1 -> MUTE, taking priority over completion of the settle count in the same clk.
REQ-019 active_source SHALL change only in SWITCH, never in PLAY, MUTE, or SETTLE.
REQ-020 Selected strobe = s0_valid when active_source=0, else s1_valid; the unselected source's inputs SHALL be ignored entirely.
REQ-021 out_valid SHALL assert exactly one clk after each selected strobe; latency fixed at 1 clk in every state.
REQ-022 out_left/out_right SHALL register the selected source's samples when the FSM is in PLAY in the strobe clk, else all-zero.
REQ-023 out_left/out_right SHALL hold their value between strobes.
REQ-024 mute SHALL be registered, equal to (state != PLAY) one clk delayed, i.e. aligned with out_* data.
REQ-025 A strobe in the SWITCH clk SHALL be taken from the newly latched source's port only from the next clk onward; in the SWITCH clk the old source is used and output is zero.
REQ-026 The settle counter SHALL saturate, never wrap, and SHALL NOT count in states other than SETTLE.
REQ-027 Steady selectionchanged=1 for any duration SHALL keep the block in MUTE with zero output and continuing out_valid strobes.

Reset
REQ-028 On reset low, asynchronously: state=SETTLE, settle counter=0, active_source=0, mute=1, out_valid=0, out_left=0, out_right=0.
REQ-029 After reset release, the first output frames SHALL be muted until SETTLE_FRAMES strobes of source 0 complete or selectionchanged asserts.
REQ-030 Reset asserted mid-operation in any state SHALL return all registers to REQ-028 values within the same clk edge-free window (asynchronous).

Verification
REQ-031 SETTLE_FRAMES=4, reset release, s0 strobe every 1024 clk with left=0x123456 -> first 4 out frames zero with mute=1, 5th out frame 0x123456 with mute=0, out_valid 1 clk after each strobe.
REQ-032 In PLAY on source 0, selectionresult=1 and selectionchanged high 65536 clk then low -> mute=1 from next frame; active_source flips to 1 exactly 2 clk after the fall; source 1 audio after 4 source-1 strobes.
REQ-033 In SETTLE at count 3 (SETTLE_FRAMES=4), selectionchanged rises in the same clk as the 4th strobe -> state MUTE, output remains zero, mute stays 1.
REQ-034 s1_valid toggling with 0x7FFFFF data while active_source=0 in PLAY -> no out_valid from s1 strobes, output carries only s0 data.
REQ-035 Reset pulsed low mid-PLAY with active_source=1 -> immediately active_source=0, mute=1, out_*=0, out_valid=0; resumes per REQ-029.
REQ-036 selectionchanged rising and falling with selectionresult unchanged (0) -> full MUTE/SWITCH/SETTLE sequence, active_source stays 0, audio returns after SETTLE_FRAMES frames.

Source files
------------

// File: rtl/source_switch_mute.sv
// Glitch-free source switch for a stereo audio stream: mutes the DAC while the
// upstream selection moves, swaps sources, then holds mute for a settle period.
module source_switch_mute #(
  parameter int DATA_WIDTH    = 24,
  parameter int SETTLE_FRAMES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  selectionresult,
  input  logic                  selectionchanged,
  input  logic                  s0_valid,
  input  logic [DATA_WIDTH-1:0] s0_left,
  input  logic [DATA_WIDTH-1:0] s0_right,
  input  logic                  s1_valid,
  input  logic [DATA_WIDTH-1:0] s1_left,
  input  logic [DATA_WIDTH-1:0] s1_right,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  mute,
  output logic                  active_source
);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_MUTE   = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_FRAMES - 1);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  state_t                state_q, state_d;
  logic [15:0]           settle_cnt_q, settle_cnt_d;
  logic                  active_source_q, active_source_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_left_q, out_left_d;
  logic [DATA_WIDTH-1:0] out_right_q, out_right_d;
  logic                  mute_q, mute_d;

  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_left;
  logic [DATA_WIDTH-1:0] sel_right;

  // Only the routed source is ever looked at; the other one is ignored entirely.
  always_comb begin
    sel_valid = active_source_q ? s1_valid : s0_valid;
    sel_left  = active_source_q ? s1_left  : s0_left;
    sel_right = active_source_q ? s1_right : s0_right;
  end

  // State register together with the FSM-owned counter and source select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_SETTLE;
      settle_cnt_q    <= '0;
      active_source_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      settle_cnt_q    <= settle_cnt_d;
      active_source_q <= active_source_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d         = state_q;
    settle_cnt_d    = settle_cnt_q;
    active_source_d = active_source_q;
    case (state_q)
      ST_PLAY: begin
        if (selectionchanged) state_d = ST_MUTE;
      end
      ST_MUTE: begin
        if (!selectionchanged) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        active_source_d = selectionresult;
        settle_cnt_d    = '0;
        state_d         = ST_SETTLE;
      end
      ST_SETTLE: begin
        // A new selection change wins over finishing the settle count.
        if (selectionchanged) begin
          state_d = ST_MUTE;
        end else if (sel_valid) begin
          if (settle_cnt_q != CNT_MAX) settle_cnt_d = settle_cnt_q + 16'd1;
          if (settle_cnt_q == SETTLE_LAST) state_d = ST_PLAY;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // Output logic: one-clock latency in every state, zero data unless playing.
  always_comb begin
    out_valid_d = sel_valid;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    mute_d      = (state_q != ST_PLAY);
    if (sel_valid) begin
      if (state_q == ST_PLAY) begin
        out_left_d  = sel_left;
        out_right_d = sel_right;
      end else begin
        out_left_d  = '0;
        out_right_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      mute_q      <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      mute_q      <= mute_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_left      = out_left_q;
  assign out_right     = out_right_q;
  assign mute          = mute_q;
  assign active_source = active_source_q;

endmodule

// File: tb/tb_source_switch_mute.sv
// Bench for source_switch_mute with SETTLE_FRAMES=4: table of frames plus
// hand-written switch / reset sequences, checked through a scoreboard queue.
module tb_source_switch_mute;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          selectionresult, selectionchanged;
  logic          s0_valid, s1_valid;
  logic [DW-1:0] s0_left, s0_right, s1_left, s1_right;
  logic          out_valid, mute, active_source;
  logic [DW-1:0] out_left, out_right;

  source_switch_mute #(.DATA_WIDTH(DW), .SETTLE_FRAMES(4)) dut (
    .clk(clk), .reset(reset),
    .selectionresult(selectionresult), .selectionchanged(selectionchanged),
    .s0_valid(s0_valid), .s0_left(s0_left), .s0_right(s0_right),
    .s1_valid(s1_valid), .s1_left(s1_left), .s1_right(s1_right),
    .out_valid(out_valid), .out_left(out_left), .out_right(out_right),
    .mute(mute), .active_source(active_source)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s0v, s1v;
    logic [DW-1:0] l0, r0, l1, r1;
    logic          ev;
    logic [DW-1:0] el, er;
    logic          em;
  } vec_t;

  typedef struct {
    int            due;
    logic          ev;
    logic [DW-1:0] el, er;
    logic          em;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s0v, input logic s1v,
                              input logic [DW-1:0] l0, input logic [DW-1:0] r0,
                              input logic [DW-1:0] l1, input logic [DW-1:0] r1,
                              input logic ev, input logic [DW-1:0] el,
                              input logic [DW-1:0] er, input logic em);
    vec_t v;
    v.s0v = s0v; v.s1v = s1v; v.l0 = l0; v.r0 = r0; v.l1 = l1; v.r1 = r1;
    v.ev = ev; v.el = el; v.er = er; v.em = em;
    return v;
  endfunction

  // Called at a negedge: one-clock strobe, expectation due on the next negedge.
  task automatic frame(input vec_t v, input int gap);
    sb_t e;
    s0_valid = v.s0v; s1_valid = v.s1v;
    s0_left = v.l0; s0_right = v.r0; s1_left = v.l1; s1_right = v.r1;
    e.due = cyc + 1; e.ev = v.ev; e.el = v.el; e.er = v.er; e.em = v.em;
    sb.push_back(e);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (gap) @(negedge clk);
    if (v.ev) chk("hold_left", out_left, v.el);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      sb_t e;
      e = sb.pop_front();
      chk("out_valid", out_valid, e.ev);
      if (e.ev) begin
        chk("out_left", out_left, e.el);
        chk("out_right", out_right, e.er);
        chk("out_mute", mute, e.em);
      end
    end else if (reset && out_valid) begin
      checks++;
      errors++;
      $display("FAIL spurious_valid: got out_valid=1 expected 0 (t=%0t)", $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[8];

  initial begin
    tbl[0] = mk(1, 0, 24'h123456, 24'h654321, 0, 0, 1, 0, 0, 1);
    tbl[1] = mk(1, 0, 24'h123456, 24'h654321, 0, 0, 1, 0, 0, 1);
    tbl[2] = mk(1, 0, 24'h123456, 24'h654321, 0, 0, 1, 0, 0, 1);
    tbl[3] = mk(1, 0, 24'h123456, 24'h654321, 0, 0, 1, 0, 0, 1);
    tbl[4] = mk(1, 0, 24'h123456, 24'h654321, 0, 0, 1, 24'h123456, 24'h654321, 0);
    tbl[5] = mk(0, 1, 0, 0, 24'h7FFFFF, 24'h7FFFFF, 0, 0, 0, 0);
    tbl[6] = mk(1, 0, 24'h800001, 24'h0F0F0F, 0, 0, 1, 24'h800001, 24'h0F0F0F, 0);
    tbl[7] = mk(1, 1, 24'h00ABCD, 24'hFFFFFF, 24'h7FFFFF, 24'h7FFFFF, 1, 24'h00ABCD, 24'hFFFFFF, 0);

    reset = 1'b0; selectionresult = 1'b0; selectionchanged = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_left = '0; s0_right = '0; s1_left = '0; s1_right = '0;
    repeat (3) @(negedge clk);
    chk("rst_mute", mute, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_left", out_left, 0);
    chk("rst_active", active_source, 0);
    reset = 1'b1;
    @(negedge clk);

    // Power-up settle, then play with s1 noise ignored.
    for (int i = 0; i < 8; i++) begin
      $display("vector %0d", i);
      frame(tbl[i], 3);
    end

    // Long selection change to source 1.
    selectionresult = 1'b1; selectionchanged = 1'b1;
    @(negedge clk); chk("mute_lag0", mute, 0);
    @(negedge clk); chk("mute_lag1", mute, 1);
    for (int i = 0; i < 20; i++) begin
      frame(mk(1, 0, 24'h111111, 24'h222222, 0, 0, 1, 0, 0, 1), 70);
      frame(mk(0, 1, 0, 0, 24'h333333, 24'h444444, 0, 0, 0, 0), 70);
    end
    chk("active_in_mute", active_source, 0);
    selectionchanged = 1'b0;
    @(negedge clk); chk("active_fall1", active_source, 0);
    @(negedge clk); chk("active_fall2", active_source, 1);
    for (int i = 0; i < 4; i++) begin
      frame(mk(0, 1, 0, 0, 24'h7FFFFF, 24'h000001, 1, 0, 0, 1), 3);
      frame(mk(1, 0, 24'h555555, 24'h555555, 0, 0, 0, 0, 0, 0), 3);
    end
    frame(mk(0, 1, 0, 0, 24'h7FFFFF, 24'h000001, 1, 24'h7FFFFF, 24'h000001, 0), 3);

    // Back to source 0, then interrupt the settle on its final strobe.
    selectionresult = 1'b0; selectionchanged = 1'b1;
    repeat (3) @(negedge clk);
    selectionchanged = 1'b0;
    repeat (3) @(negedge clk);
    chk("active_back0", active_source, 0);
    for (int i = 0; i < 3; i++)
      frame(mk(1, 0, 24'h0AAAAA, 24'h0BBBBB, 0, 0, 1, 0, 0, 1), 3);
    selectionchanged = 1'b1;
    frame(mk(1, 0, 24'h0AAAAA, 24'h0BBBBB, 0, 0, 1, 0, 0, 1), 3);
    frame(mk(1, 0, 24'h0CCCCC, 24'h0DDDDD, 0, 0, 1, 0, 0, 1), 3);
    chk("mute_interrupt", mute, 1);

    // Change that leaves the selection at source 0.
    selectionchanged = 1'b0;
    @(negedge clk); chk("same_src1", active_source, 0);
    @(negedge clk); chk("same_src2", active_source, 0);
    for (int i = 0; i < 4; i++)
      frame(mk(1, 0, 24'h246802, 24'h135791, 0, 0, 1, 0, 0, 1), 3);
    frame(mk(1, 0, 24'h246802, 24'h135791, 0, 0, 1, 24'h246802, 24'h135791, 0), 3);

    // Reach play on source 1, then reset mid-frame.
    selectionresult = 1'b1; selectionchanged = 1'b1;
    repeat (3) @(negedge clk);
    selectionchanged = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      frame(mk(0, 1, 0, 0, 24'h600DF0, 24'h0D0D0D, 1, 0, 0, 1), 3);
    frame(mk(0, 1, 0, 0, 24'h600DF0, 24'h0D0D0D, 1, 24'h600DF0, 24'h0D0D0D, 0), 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_mute", mute, 1);
    chk("arst_left", out_left, 0);
    chk("arst_right", out_right, 0);
    chk("arst_active", active_source, 0);
    @(negedge clk);
    selectionresult = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      frame(mk(1, 0, 24'h3C3C3C, 24'hC3C3C3, 0, 0, 1, 0, 0, 1), 3);
      frame(mk(0, 1, 0, 0, 24'h7FFFFF, 24'h7FFFFF, 0, 0, 0, 0), 3);
    end
    frame(mk(1, 0, 24'h3C3C3C, 24'hC3C3C3, 0, 0, 1, 24'h3C3C3C, 24'hC3C3C3, 0), 3);

    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
